// File: rtl/blur_pkg.sv
// Shared state encoding, default geometry and width helper for the blur frame sequencer.
package blur_pkg;

    localparam int IMG_WIDTH_DEF  = 512;
    localparam int IMG_HEIGHT_DEF = 512;
    localparam int PIX_W_DEF      = 8;
    localparam int NUM_LB_DEF     = 4;
    localparam int CRED_W         = 3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_SEND  = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        SEND  = ST_SEND,
        WAIT  = ST_WAIT,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } seq_state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/blur_frame_sequencer_credit.sv
// Line-buffer credit counter: one credit per free downstream line buffer, sticky overflow flag.
module line_credit_counter
    import blur_pkg::*;
#(
    parameter int NUM_LB = NUM_LB_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              clr_err_i,
    input  logic              inc_i,
    input  logic              dec_i,
    output logic [CRED_W-1:0] credits_o,
    output logic              err_o
);

    localparam logic [CRED_W-1:0] FULL = CRED_W'(NUM_LB);

    logic [CRED_W-1:0] credits_q, credits_d;
    logic              err_q, err_d;

    // A freed buffer arriving with a line completion cancels out.
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        if (clr_err_i) begin
            err_d = 1'b0;
        end
        if (load_i) begin
            credits_d = FULL;
        end else if (inc_i && !dec_i) begin
            if (credits_q == FULL) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q + CRED_W'(1);
            end
        end else if (dec_i && !inc_i) begin
            credits_d = credits_q - CRED_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credits_q <= '0;
            err_q     <= 1'b0;
        end else begin
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

    assign credits_o = credits_q;
    assign err_o     = err_q;

endmodule

// File: rtl/blur_frame_sequencer.sv
// Credit-based line scheduler feeding the 4-line-buffer 3x3 blur front end.
// BLUR_EDGE_PAD_EN adds a zero pad line above and below the source frame.
module blur_frame_sequencer
    import blur_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int PIX_W      = PIX_W_DEF,
    parameter int NUM_LB     = NUM_LB_DEF
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic                              i_start,
    input  logic                              i_abort,
    input  logic [PIX_W-1:0]                  i_src_data,
    input  logic                              i_src_valid,
    output logic                              o_src_ready,
    output logic [PIX_W-1:0]                  o_pixel_data,
    output logic                              o_pixel_data_valid,
    input  logic                              i_intr,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_err,
    output logic [$clog2(IMG_HEIGHT+3)-1:0]   o_lines_sent,
    output seq_state_t                        o_state
);

`ifdef BLUR_EDGE_PAD_EN
    localparam int TOTAL_LINES = IMG_HEIGHT + 2;
`else
    localparam int TOTAL_LINES = IMG_HEIGHT;
`endif
    localparam int EXP_INTR = TOTAL_LINES - 2;
    localparam int PIX_CW   = cnt_w(IMG_WIDTH);
    localparam int LINES_W  = $clog2(IMG_HEIGHT + 3);

    localparam logic [PIX_CW-1:0]  LAST_PIX   = PIX_CW'(IMG_WIDTH - 1);
    localparam logic [LINES_W-1:0] LAST_LINE  = LINES_W'(TOTAL_LINES - 1);
    localparam logic [LINES_W-1:0] ALL_LINES  = LINES_W'(TOTAL_LINES);
    localparam logic [LINES_W:0]   EXP_INTR_W = (LINES_W + 1)'(EXP_INTR);

    seq_state_t         state_q, state_d;
    logic [PIX_CW-1:0]  pix_q, pix_d;
    logic [LINES_W-1:0] line_q, line_d;
    logic [LINES_W-1:0] intr_q, intr_d;
    logic [PIX_W-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               busy_q;

    logic [CRED_W-1:0]  credits;
    logic               cred_err;
    logic               pad_line, send_ok, beat, line_done, inc;
    logic [LINES_W:0]   intr_sum;

`ifdef BLUR_EDGE_PAD_EN
    assign pad_line = (line_q == '0) || (line_q == LAST_LINE);
`else
    assign pad_line = 1'b0;
`endif

    // Pad lines are generated internally, so they advance without the source.
    assign send_ok     = (state_q == SEND) && (credits != '0);
    assign o_src_ready = send_ok && !pad_line;
    assign beat        = send_ok && (pad_line || i_src_valid);
    assign line_done   = beat && (pix_q == LAST_PIX);
    assign inc         = i_intr && (state_q != IDLE) && (state_q != LOAD);
    assign intr_sum    = {1'b0, intr_q} + {{LINES_W{1'b0}}, inc};

    line_credit_counter #(.NUM_LB(NUM_LB)) u_credit (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .load_i    (state_q == LOAD),
        .clr_err_i ((state_q == IDLE) && i_start),
        .inc_i     (inc),
        .dec_i     (line_done),
        .credits_o (credits),
        .err_o     (cred_err)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (i_start) state_d = LOAD;
            LOAD:  state_d = SEND;
            SEND: begin
                if (line_done) begin
                    if (!inc && (credits == CRED_W'(1))) begin
                        state_d = WAIT;
                    end else if (line_q == LAST_LINE) begin
                        state_d = DRAIN;
                    end
                end
            end
            WAIT:  if (credits != '0) state_d = (line_q == ALL_LINES) ? DRAIN : SEND;
            DRAIN: if (intr_sum >= EXP_INTR_W) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (i_abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        pix_d   = pix_q;
        line_d  = line_q;
        intr_d  = intr_q;
        data_d  = data_q;
        valid_d = beat && !i_abort;
        if (state_q == LOAD) begin
            pix_d  = '0;
            line_d = '0;
            intr_d = '0;
        end else begin
            if (beat) begin
                pix_d  = (pix_q == LAST_PIX) ? '0 : pix_q + PIX_CW'(1);
                data_d = pad_line ? '0 : i_src_data;
            end
            if (line_done) line_d = line_q + LINES_W'(1);
            if (inc)       intr_d = intr_q + LINES_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            pix_q   <= '0;
            line_q  <= '0;
            intr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pix_q   <= pix_d;
            line_q  <= line_d;
            intr_q  <= intr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= state_d inside {SEND, WAIT, DRAIN};
        end
    end

    assign o_pixel_data       = data_q;
    assign o_pixel_data_valid = valid_q;
    assign o_busy             = busy_q;
    assign o_done             = (state_q == DONE);
    assign o_err              = cred_err;
    assign o_lines_sent       = line_q;
    assign o_state            = state_q;

endmodule
